// File: rtl/alu_2bit_seq.sv
// Sequenced 2-bit signed ALU responder with valid/ready request and response.
// MUL runs as a two-step shift-add; every other op finishes in one cycle.
module alu_2bit_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       A,
    input  logic [1:0]       B,
    input  logic             Cin,
    input  logic [2:0]       control,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t     state;
    logic [1:0] a_q;
    logic       b1_q;
    logic [3:0] acc;

    logic [3:0] sa;
    logic [3:0] sb;
    logic [3:0] cin4;
    logic [1:0] lg;
    logic [3:0] op_res;
    logic [3:0] mul_init;
    logic [3:0] mul_sub;
    logic       accept;

    assign sa   = {{2{A[1]}}, A};
    assign sb   = {{2{B[1]}}, B};
    assign cin4 = {3'b000, Cin};

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        lg     = 2'b00;
        op_res = 4'b0000;
        unique case (control)
            OP_AND: begin
                lg     = A & B;
                op_res = {{2{lg[1]}}, lg};
            end
            OP_OR: begin
                lg     = A | B;
                op_res = {{2{lg[1]}}, lg};
            end
            OP_XOR: begin
                lg     = A ^ B;
                op_res = {{2{lg[1]}}, lg};
            end
            OP_NOT: begin
                lg     = ~A;
                op_res = {{2{lg[1]}}, lg};
            end
            OP_ADD: op_res = sa + sb + cin4;
            OP_SUB: op_res = sa - sb - cin4;
            OP_MUL: op_res = 4'b0000;
            OP_CMP: begin
                if ($signed(sa) > $signed(sb))
                    op_res = 4'b0001;
                else if (sa == sb)
                    op_res = 4'b0000;
                else
                    op_res = 4'b1111;
            end
            default: op_res = 4'b0000;
        endcase
    end

    // B[1] carries weight -2, so the second partial product is subtracted
    assign mul_init = B[0] ? sa : 4'b0000;
    assign mul_sub  = b1_q ? {a_q[1], a_q, 1'b0} : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= 2'b00;
            b1_q     <= 1'b0;
            acc      <= 4'b0000;
            result   <= 4'b0000;
            op_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q  <= A;
                        b1_q <= B[1];
                        if (control == OP_MUL) begin
                            acc   <= mul_init;
                            state <= MUL1;
                        end else begin
                            result <= op_res;
                            state  <= RESP;
                        end
                    end
                end
                MUL1: begin
                    acc    <= acc - mul_sub;
                    result <= acc - mul_sub;
                    state  <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_2bit_seq.sv
// Self-checking bench for alu_2bit_seq against an integer-arithmetic model.
// Each feature task drives its own stimulus and compares inline.
module tb_alu_2bit_seq;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] A;
    logic [1:0] B;
    logic       Cin;
    logic [2:0] control;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] result;
    logic       busy;
    logic [7:0] op_count;

    int checks;
    int errors;
    int exp_count;

    alu_2bit_seq #(.CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .A(A),
        .B(B),
        .Cin(Cin),
        .control(control),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .result(result),
        .busy(busy),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic [1:0] a, input logic [1:0] b,
                                         input logic cin, input logic [2:0] op);
        int sa;
        int sb;
        int r;
        logic [1:0] t;
        sa = $signed(a);
        sb = $signed(b);
        r = 0;
        case (op)
            3'd0: begin t = a & b; r = $signed(t); end
            3'd1: begin t = a | b; r = $signed(t); end
            3'd2: begin t = a ^ b; r = $signed(t); end
            3'd3: begin t = ~a;    r = $signed(t); end
            3'd4: r = sa + sb + int'(cin);
            3'd5: r = sa - sb - int'(cin);
            3'd6: r = sa * sb;
            default: r = (sa > sb) ? 1 : ((sa == sb) ? 0 : -1);
        endcase
        return r[3:0];
    endfunction

    function automatic int latency_of(input logic [2:0] op);
        return (op == 3'd6) ? 2 : 1;
    endfunction

    // Present a request on the next negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] a, input logic [1:0] b,
                         input logic cin, input logic [2:0] op);
        @(negedge clk);
        A = a; B = b; Cin = cin; control = op;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        A = 2'($urandom); B = 2'($urandom);
        Cin = 1'($urandom); control = 3'($urandom);
    endtask

    // Cycles from the acceptance edge until rsp_valid; 99 on timeout.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) lat = 99;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
    endtask

    task automatic run_op(input string name, input logic [1:0] a, input logic [1:0] b,
                          input logic cin, input logic [2:0] op);
        int lat;
        logic [3:0] exp;
        exp = model(a, b, cin, op);
        issue(a, b, cin, op);
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s in_flight req_ready=%b busy=%b required 0/1", name, req_ready, busy);
        end
        wait_rsp(lat);
        checks++;
        if (lat !== latency_of(op)) begin
            errors++;
            $display("FAIL %s latency got %0d required %0d", name, lat, latency_of(op));
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result got %b required %b (A=%b B=%b Cin=%b op=%b)",
                     name, result, exp, a, b, cin, op);
        end
        ack();
        checks++;
        if (op_count !== 8'(exp_count) || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s op_count got %0d required %0d rsp_valid=%b",
                     name, op_count, exp_count, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== 4'd0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            op_count !== 8'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got res=%b rv=%b busy=%b cnt=%0d rr=%b required 0000/0/0/0/1",
                     result, rsp_valid, busy, op_count, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release req_ready got %b required 1", req_ready);
        end
    endtask

    task automatic test_add();
        run_op("add_1_1_1", 2'b01, 2'b01, 1'b1, 3'b100);
    endtask

    task automatic test_sub();
        run_op("sub_m1_m2", 2'b11, 2'b10, 1'b0, 3'b101);
        run_op("sub_m2_1_c", 2'b10, 2'b01, 1'b1, 3'b101);
    endtask

    task automatic test_mul();
        run_op("mul_m2_1", 2'b10, 2'b01, 1'b0, 3'b110);
        run_op("mul_m1_m2", 2'b11, 2'b10, 1'b0, 3'b110);
        run_op("mul_m2_m2", 2'b10, 2'b10, 1'b0, 3'b110);
    endtask

    task automatic test_sweep();
        for (int op = 0; op < 8; op++)
            run_op($sformatf("sweep_op%0d", op), 2'b10, 2'b01, 1'($urandom), 3'(op));
    endtask

    task automatic test_backpressure();
        logic [3:0] exp;
        int lat;
        exp = model(2'b01, 2'b11, 1'b1, 3'b101);
        issue(2'b01, 2'b11, 1'b1, 3'b101);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = 2'($urandom); B = 2'($urandom);
            control = 3'($urandom); req_valid = 1'($urandom);
            rsp_ready = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (result !== exp || rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
                op_count !== 8'(exp_count)) begin
                errors++;
                $display("FAIL backpressure cyc%0d res=%b rv=%b rr=%b cnt=%0d required %b/1/0/%0d",
                         i, result, rsp_valid, req_ready, op_count, exp, exp_count);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        ack();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (op_count !== 8'(exp_count) || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release cnt=%0d rv=%b required %0d/0",
                     op_count, rsp_valid, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        seen = 0;
        @(negedge clk);
        A = 2'b01; B = 2'b10; Cin = 1'b0; control = 3'b100;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen++;
                checks++;
                if (result !== model(2'b01, 2'b10, 1'b0, 3'b100)) begin
                    errors++;
                    $display("FAIL back_to_back result got %b required 1111", result);
                end
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_count = (exp_count + 5) % 256;
        checks++;
        if (seen !== 5) begin
            errors++;
            $display("FAIL back_to_back responses got %0d required 5", seen);
        end
        @(posedge clk);
        #1;
        checks++;
        if (op_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL back_to_back op_count got %0d required %0d", op_count, exp_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op($sformatf("rand%0d", i), 2'($urandom), 2'($urandom),
                   1'($urandom), 3'($urandom));
    endtask

    task automatic test_reset_mid_mul();
        issue(2'b11, 2'b11, 1'b0, 3'b110);
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || result !== 4'd0 || op_count !== 8'd0 ||
            req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul rv=%b res=%b cnt=%0d rr=%b busy=%b required 0/0000/0/1/0",
                     rsp_valid, result, op_count, req_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_mul_after rv=%b rr=%b cnt=%0d required 0/1/0",
                     rsp_valid, req_ready, op_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            int lat;
            logic [1:0] a;
            logic [1:0] b;
            logic       c;
            logic [2:0] op;
            a = 2'($urandom); b = 2'($urandom);
            c = 1'($urandom); op = 3'($urandom);
            issue(a, b, c, op);
            wait_rsp(lat);
            if (lat == 99 || result !== model(a, b, c, op)) begin
                checks++;
                errors++;
                $display("FAIL wrap_op%0d result got %b required %b lat=%0d",
                         i, result, model(a, b, c, op), lat);
            end
            ack();
            if (i == 254) begin
                checks++;
                if (op_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255 op_count got %0d required 255", op_count);
                end
            end
        end
        checks++;
        if (op_count !== 8'd0 || exp_count != 0) begin
            errors++;
            $display("FAIL wrap op_count got %0d required 0", op_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_count = 0;
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        A = 2'b00; B = 2'b00; Cin = 1'b0; control = 3'b000;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
